// File: rtl/m_board_arbiter.sv
// Connect-Four board owner: arbitrates move requests from the human and AI
// sides, sequences the shared m_piler and commits or rejects each move.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef COL_COUNT
`define COL_COUNT 7
`endif
`ifndef FIELD_SIZE
`define FIELD_SIZE 42
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif

module m_board_arbiter #(
    parameter bit ENFORCE_TURN = 1'b1,
    parameter int MAX_MOVES    = 42,
    parameter bit FIRST_TURN   = 1'b0
) (
    input  logic                                w_clk,
    input  logic                                w_rst,
    input  logic                                i_clear,
    input  logic [1:0]                          i_req,
    input  logic [`COL_SIZE-1:0]                i_col0,
    input  logic [`COL_SIZE-1:0]                i_col1,
    output logic [1:0]                          o_ack,
    output logic [1:0]                          o_nack,
    output logic [`FIELD_SIZE-1:0]              o_pl_field,
    output logic [`PILED_COUNT_ARRAY_SIZE-1:0]  o_pl_array,
    output logic [`COL_SIZE-1:0]                o_pl_col,
    input  logic                                i_pl_valid,
    input  logic [`FIELD_SIZE-1:0]              i_pl_field,
    input  logic [`PILED_COUNT_ARRAY_SIZE-1:0]  i_pl_array,
    output logic [`FIELD_SIZE-1:0]              o_field0,
    output logic [`FIELD_SIZE-1:0]              o_field1,
    output logic [`PILED_COUNT_ARRAY_SIZE-1:0]  o_piled_array,
    output logic [5:0]                          o_move_count,
    output logic                                o_turn,
    output logic [`COL_SIZE-1:0]                o_last_col,
    output logic                                o_busy,
    output logic                                o_full
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PILE = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state;
    logic                 last_grant;
    logic                 grantee;
    logic [`COL_SIZE-1:0] grant_col_q;

    logic                 grant;
    logic [`COL_SIZE-1:0] grant_col;
    logic                 reject;

    // Round-robin: with both requesting, the side not granted last time wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        grant = 1'b0;
        case (i_req)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
        grant_col = grant ? i_col1 : i_col0;
        reject    = (int'(grant_col) >= `COL_COUNT) || o_full ||
                    (ENFORCE_TURN && (grant != o_turn));
    end

    assign o_busy = (state != IDLE);
    assign o_full = (o_move_count == 6'(MAX_MOVES));

    // NOTE: state is updated with non-blocking assignments only; async reset covers every register.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state         <= IDLE;
            last_grant    <= ~FIRST_TURN;
            grantee       <= 1'b0;
            grant_col_q   <= '0;
            o_ack         <= '0;
            o_nack        <= '0;
            o_pl_field    <= '0;
            o_pl_array    <= '0;
            o_pl_col      <= '0;
            o_field0      <= '0;
            o_field1      <= '0;
            o_piled_array <= '0;
            o_move_count  <= '0;
            o_turn        <= FIRST_TURN;
            o_last_col    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_ack  <= '0;
                    o_nack <= '0;
                    if (i_clear) begin
                        o_field0      <= '0;
                        o_field1      <= '0;
                        o_piled_array <= '0;
                        o_move_count  <= '0;
                        o_last_col    <= '0;
                        o_turn        <= FIRST_TURN;
                        last_grant    <= ~FIRST_TURN;
                    end else if (|i_req) begin
                        last_grant  <= grant;
                        grantee     <= grant;
                        grant_col_q <= grant_col;
                        if (reject) begin
                            o_nack <= 2'b01 << grant;
                            state  <= RESP;
                        end else begin
                            o_pl_field <= grant ? o_field1 : o_field0;
                            o_pl_array <= o_piled_array;
                            o_pl_col   <= grant_col;
                            state      <= PILE;
                        end
                    end
                end
                PILE: begin
                    if (i_pl_valid) begin
                        if (grantee) o_field1 <= i_pl_field;
                        else         o_field0 <= i_pl_field;
                        o_piled_array <= i_pl_array;
                        if (o_move_count < 6'(MAX_MOVES))
                            o_move_count <= o_move_count + 6'd1;
                        o_last_col <= grant_col_q;
                        o_turn     <= ~grantee;
                        o_ack      <= 2'b01 << grantee;
                    end else begin
                        o_nack <= 2'b01 << grantee;
                    end
                    o_pl_field <= '0;
                    o_pl_array <= '0;
                    o_pl_col   <= '0;
                    state      <= RESP;
                end
                RESP: begin
                    o_ack  <= '0;
                    o_nack <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m_board_arbiter.sv
// Directed bench for m_board_arbiter with a behavioural piler model driving
// the piler result inputs.
`ifndef COL_SIZE
`define COL_SIZE 3
`endif
`ifndef COL_COUNT
`define COL_COUNT 7
`endif
`ifndef FIELD_SIZE
`define FIELD_SIZE 42
`endif
`ifndef PILED_COUNT_ARRAY_SIZE
`define PILED_COUNT_ARRAY_SIZE 21
`endif

module tb_m_board_arbiter;

    logic                               w_clk = 1'b0;
    logic                               w_rst = 1'b0;
    logic                               clear = 1'b0;
    logic [1:0]                         req = 2'b00;
    logic [`COL_SIZE-1:0]               col0 = '0, col1 = '0;
    logic [1:0]                         ack, nack;
    logic [`FIELD_SIZE-1:0]             pl_field, pl_field_r, field0, field1;
    logic [`PILED_COUNT_ARRAY_SIZE-1:0] pl_array, pl_array_r, piled;
    logic [`COL_SIZE-1:0]               pl_col, last_col;
    logic                               pl_valid, turn, busy, full;
    logic [5:0]                         move_count;
    bit                                 force_invalid = 1'b0;
    int                                 total = 0;
    int                                 bad = 0;

    localparam logic [41:0] EVEN_BITS = 42'h15555555555;
    localparam logic [41:0] ODD_BITS  = 42'h2AAAAAAAAAA;
    localparam logic [20:0] ALL_SIX   = {7{3'b110}};

    always #5 w_clk = ~w_clk;

    m_board_arbiter dut (
        .w_clk(w_clk), .w_rst(w_rst), .i_clear(clear), .i_req(req),
        .i_col0(col0), .i_col1(col1), .o_ack(ack), .o_nack(nack),
        .o_pl_field(pl_field), .o_pl_array(pl_array), .o_pl_col(pl_col),
        .i_pl_valid(pl_valid), .i_pl_field(pl_field_r), .i_pl_array(pl_array_r),
        .o_field0(field0), .o_field1(field1), .o_piled_array(piled),
        .o_move_count(move_count), .o_turn(turn), .o_last_col(last_col),
        .o_busy(busy), .o_full(full)
    );

    // Piler model: drop a piece on top of the column unless it holds six.
    always_comb begin
        int c;
        int cnt;
        c          = int'(pl_col);
        cnt        = 0;
        pl_valid   = 1'b0;
        pl_field_r = pl_field;
        pl_array_r = pl_array;
        if (c < `COL_COUNT) begin
            cnt = int'(pl_array[c*3 +: 3]);
            if (cnt < 6 && !force_invalid) begin
                pl_valid   = 1'b1;
                pl_field_r = pl_field | (42'd1 << (c*6 + cnt));
                pl_array_r = pl_array + (21'd1 << (c*3));
            end
        end
    end

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic do_reset();
        req = 2'b00; clear = 1'b0; force_invalid = 1'b0;
        w_rst = 1'b1;
        tick(); tick();
        w_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (field0 !== '0 || field1 !== '0) begin bad++; $display("FAIL reset_fields got %h %h want 0 0", field0, field1); end
        total++; if (piled !== '0) begin bad++; $display("FAIL reset_array got %h want 0", piled); end
        total++; if (move_count !== 6'd0 || turn !== 1'b0 || last_col !== '0) begin bad++; $display("FAIL reset_regs got cnt=%0d turn=%b col=%0d want 0 0 0", move_count, turn, last_col); end
        total++; if (busy !== 1'b0 || full !== 1'b0 || ack !== 2'b00 || nack !== 2'b00) begin bad++; $display("FAIL reset_flags got busy=%b full=%b ack=%b nack=%b want 0 0 00 00", busy, full, ack, nack); end
        total++; if (pl_col !== '0 || pl_field !== '0) begin bad++; $display("FAIL reset_pl got col=%0d field=%h want 0 0", pl_col, pl_field); end
    endtask

    task automatic test_single_move();
        do_reset();
        col0 = 3'd3; req = 2'b01;
        tick();
        total++; if (busy !== 1'b1 || ack !== 2'b00 || pl_col !== 3'd3) begin bad++; $display("FAIL single_pile got busy=%b ack=%b pl_col=%0d want 1 00 3", busy, ack, pl_col); end
        tick();
        total++; if (ack !== 2'b01 || nack !== 2'b00) begin bad++; $display("FAIL single_ack got ack=%b nack=%b want 01 00", ack, nack); end
        total++; if (field0 !== 42'd1 << 18 || piled !== 21'd1 << 9) begin bad++; $display("FAIL single_board got f0=%h arr=%h want %h %h", field0, piled, 42'd1 << 18, 21'd1 << 9); end
        total++; if (move_count !== 6'd1 || turn !== 1'b1 || last_col !== 3'd3) begin bad++; $display("FAIL single_regs got cnt=%0d turn=%b col=%0d want 1 1 3", move_count, turn, last_col); end
        req = 2'b00;
        tick();
        total++; if (busy !== 1'b0 || ack !== 2'b00) begin bad++; $display("FAIL single_idle got busy=%b ack=%b want 0 00", busy, ack); end
    endtask

    task automatic test_both_requests();
        do_reset();
        col0 = 3'd2; col1 = 3'd5; req = 2'b11;
        tick();
        total++; if (pl_col !== 3'd2) begin bad++; $display("FAIL both_first_grant got pl_col=%0d want 2", pl_col); end
        tick();
        total++; if (ack !== 2'b01) begin bad++; $display("FAIL both_ack0 got %b want 01", ack); end
        req = 2'b10;
        tick();
        tick();
        total++; if (pl_col !== 3'd5 || busy !== 1'b1) begin bad++; $display("FAIL both_second_grant got pl_col=%0d busy=%b want 5 1", pl_col, busy); end
        tick();
        total++; if (ack !== 2'b10) begin bad++; $display("FAIL both_ack1 got %b want 10", ack); end
        total++; if (field0 !== 42'd1 << 12 || field1 !== 42'd1 << 30) begin bad++; $display("FAIL both_fields got %h %h want %h %h", field0, field1, 42'd1 << 12, 42'd1 << 30); end
        total++; if (piled !== 21'h8040 || move_count !== 6'd2 || turn !== 1'b0) begin bad++; $display("FAIL both_regs got arr=%h cnt=%0d turn=%b want 8040 2 0", piled, move_count, turn); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_turn_reject();
        col1 = 3'd4; req = 2'b10;
        tick();
        total++; if (nack !== 2'b10 || ack !== 2'b00) begin bad++; $display("FAIL turn_nack got nack=%b ack=%b want 10 00", nack, ack); end
        req = 2'b00;
        tick();
        total++; if (busy !== 1'b0 || move_count !== 6'd2 || piled !== 21'h8040 || field1 !== 42'd1 << 30 || turn !== 1'b0) begin bad++; $display("FAIL turn_unchanged got busy=%b cnt=%0d arr=%h f1=%h turn=%b", busy, move_count, piled, field1, turn); end
    endtask

    task automatic test_bad_col();
        col0 = 3'd7; req = 2'b01;
        tick();
        total++; if (nack !== 2'b01 || pl_col !== 3'd0) begin bad++; $display("FAIL badcol got nack=%b pl_col=%0d want 01 0", nack, pl_col); end
        req = 2'b00;
        tick();
        total++; if (move_count !== 6'd2 || busy !== 1'b0) begin bad++; $display("FAIL badcol_after got cnt=%0d busy=%b want 2 0", move_count, busy); end
    endtask

    task automatic test_pile_invalid();
        force_invalid = 1'b1;
        col0 = 3'd5; req = 2'b01;
        tick();
        total++; if (busy !== 1'b1 || nack !== 2'b00) begin bad++; $display("FAIL invalid_pile got busy=%b nack=%b want 1 00", busy, nack); end
        tick();
        total++; if (nack !== 2'b01 || ack !== 2'b00) begin bad++; $display("FAIL invalid_nack got nack=%b ack=%b want 01 00", nack, ack); end
        total++; if (move_count !== 6'd2 || turn !== 1'b0 || field0 !== 42'd1 << 12 || last_col !== 3'd5) begin bad++; $display("FAIL invalid_state got cnt=%0d turn=%b f0=%h col=%0d", move_count, turn, field0, last_col); end
        req = 2'b00; force_invalid = 1'b0;
        tick();
    endtask

    task automatic test_fill_board();
        do_reset();
        for (int i = 0; i < 42; i++) begin
            if (i % 2 == 0) begin col0 = 3'(i / 6); req = 2'b01; end
            else            begin col1 = 3'(i / 6); req = 2'b10; end
            tick(); tick();
            total++; if (ack !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL fill_ack move=%0d got %b", i, ack); end
            req = 2'b00;
            tick();
        end
        total++; if (move_count !== 6'd42 || full !== 1'b1 || last_col !== 3'd6) begin bad++; $display("FAIL fill_count got cnt=%0d full=%b col=%0d want 42 1 6", move_count, full, last_col); end
        total++; if (field0 !== EVEN_BITS || field1 !== ODD_BITS || piled !== ALL_SIX) begin bad++; $display("FAIL fill_board got %h %h %h want %h %h %h", field0, field1, piled, EVEN_BITS, ODD_BITS, ALL_SIX); end
        col0 = 3'd0; req = 2'b01;
        tick();
        total++; if (nack !== 2'b01 || ack !== 2'b00) begin bad++; $display("FAIL full_nack got nack=%b ack=%b want 01 00", nack, ack); end
        req = 2'b00;
        tick();
        total++; if (move_count !== 6'd42) begin bad++; $display("FAIL full_saturate got %0d want 42", move_count); end
    endtask

    task automatic test_clear();
        clear = 1'b1; col0 = 3'd1; req = 2'b01;
        tick();
        total++; if (busy !== 1'b0 || field0 !== '0 || field1 !== '0 || piled !== '0) begin bad++; $display("FAIL clear_board got busy=%b %h %h %h want 0 0 0 0", busy, field0, field1, piled); end
        total++; if (move_count !== 6'd0 || turn !== 1'b0 || last_col !== '0 || full !== 1'b0) begin bad++; $display("FAIL clear_regs got cnt=%0d turn=%b col=%0d full=%b want 0 0 0 0", move_count, turn, last_col, full); end
        clear = 1'b0; req = 2'b00;
        tick();
        total++; if (ack !== 2'b00 || nack !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL clear_noresp got ack=%b nack=%b busy=%b want 00 00 0", ack, nack, busy); end
    endtask

    task automatic test_reset_mid_pile();
        col0 = 3'd2; req = 2'b01;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_pile got busy=%b want 1", busy); end
        #2 w_rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || ack !== 2'b00 || move_count !== 6'd0 || pl_col !== '0) begin bad++; $display("FAIL midrst_async got busy=%b ack=%b cnt=%0d pl_col=%0d want 0 00 0 0", busy, ack, move_count, pl_col); end
        req = 2'b00;
        tick();
        w_rst = 1'b0;
        tick();
        total++; if (ack !== 2'b00 || nack !== 2'b00 || field0 !== '0 || move_count !== 6'd0) begin bad++; $display("FAIL midrst_after got ack=%b nack=%b f0=%h cnt=%0d want 00 00 0 0", ack, nack, field0, move_count); end
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_both_requests();
        test_turn_reject();
        test_bad_col();
        test_pile_invalid();
        test_fill_board();
        test_clear();
        test_reset_mid_pile();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_board_arbiter.md
# m_board_arbiter

Owns the Connect-Four board state (both players' fields and the per-column pile counts) and is the only writer of it. Arbitrates move requests from two requesters, the human-input side (requester 0) and the AI side (requester 1), with a round-robin policy and optional strict turn order. For each granted move it sequences the shared combinational `m_piler` and commits or rejects the result. It sits between the input/AI controllers and the display path and replaces per-controller board registers.

## Interface
Parameters:
- ENFORCE_TURN, 1: when 1, a request from the side not on turn is rejected.
- MAX_MOVES, 42: number of committed moves at which the board is full.
- FIRST_TURN, 0: requester that is on turn after reset or clear.

Ports:
- w_clk  in  1  clock; all state changes on rising edge.
- w_rst  in  1  reset; asynchronous, active-high.
- i_clear  in  1  synchronous board clear; honoured only in IDLE.
- i_req  in  2  level move request, bit n = requester n; held until that requester's ack or nack.
- i_col0, i_col1  in  `COL_SIZE  requested column per requester.
- o_ack, o_nack  out  2  one-cycle response pulse per requester.
- o_pl_field  out  `FIELD_SIZE  piler field input (granted player's field).
- o_pl_array  out  `PILED_COUNT_ARRAY_SIZE  piler pile-count input.
- o_pl_col  out  `COL_SIZE  piler column input.
- i_pl_valid  in  1  piler result valid (0 = column full).
- i_pl_field  in  `FIELD_SIZE  piler result field.
- i_pl_array  in  `PILED_COUNT_ARRAY_SIZE  piler result pile counts.
- o_field0, o_field1  out  `FIELD_SIZE  committed fields of requester 0 and 1.
- o_piled_array  out  `PILED_COUNT_ARRAY_SIZE  committed pile counts.
- o_move_count  out  6  number of committed moves.
- o_turn  out  1  requester currently on turn.
- o_last_col  out  `COL_SIZE  column of the most recent committed move.
- o_busy  out  1  high in every state except IDLE.
- o_full  out  1  o_move_count == MAX_MOVES.

## Operation
- States: IDLE, PILE, RESP.
- Reset values: state IDLE, fields/array/move_count/last_col 0, o_turn = FIRST_TURN, last-grant pointer = ~FIRST_TURN, ack/nack 0.
- IDLE, i_clear=1: fields, array, move_count, last_col go to 0; o_turn = FIRST_TURN; pointer = ~FIRST_TURN. Requests in the same cycle are ignored. Stay in IDLE.
- IDLE, no clear, any i_req bit set:
  - Grant selection: the single requester if only one is requesting. If both request, grant the one not equal to the last-grant pointer. Update the pointer to the grantee. Latch the grantee and its column.
  - Reject conditions: column ≥ `COL_COUNT`, or o_full, or (ENFORCE_TURN and grantee ≠ o_turn). On reject, set nack[grantee] and go to RESP. The piler is not used.
  - Otherwise go to PILE.
- PILE: o_pl_field = latched grantee's field, o_pl_array = committed array, o_pl_col = latched column.
  - If i_pl_valid: write i_pl_field to the grantee's field and i_pl_array to the array; move_count += 1; last_col = column; o_turn = ~grantee; ack[grantee] = 1.
  - Else: nack[grantee] = 1 and nothing else changes.
  - Go to RESP.
- RESP: ack/nack high for this cycle only. All requests are ignored. Next state IDLE, with ack/nack cleared.
- Outside PILE, the o_pl_* outputs drive field 0, array 0 and column 0.
- The ungranted requester keeps its request pending. It is served in the next IDLE.
- The move counter saturates at MAX_MOVES and never wraps.

## Timing
- Valid request, req sampled high in IDLE at edge T:
  - PILE during cycle T+1; commit at edge T+2.
  - ack high and new fields visible during T+2.
  - IDLE again at T+3.
- Latency is 2 cycles to ack; throughput is one move per 3 cycles.
- Reject in IDLE: nack during T+1, IDLE at T+2.
- Requester protocol:
  - Drop req in the cycle after seeing its ack/nack.
  - A req still high when IDLE is re-entered is treated as a new request.
- Asserting w_rst in any state returns all state to reset values immediately. A move in PILE is discarded. No ack or nack is issued.
- i_clear asserted in PILE or RESP is ignored. It must be held until IDLE.

## Test plan
- Reset, then req=01 with col0=3 and the piler returning valid with array bits[11:9]=1: ack[0] at T+2, o_field0 reflects the piler result, move_count=1, o_turn=1, o_last_col=3.
- req=11 immediately after reset with FIRST_TURN=0 and ENFORCE_TURN=0: requester 0 is acked first. Requester 1, still holding req, is acked in the next arbitration (T+5). move_count=2.
- ENFORCE_TURN=1 with o_turn=0 and req=10: nack[1] at T+1. Fields, array and move_count are unchanged.
- col0=7: nack[0] at T+1, and o_pl_col stays 0 (the piler is never driven).
- Piler returns i_pl_valid=0 for a full column: nack at T+2, state unchanged, o_turn unchanged.
- Run 42 accepted moves, then make a 43rd request: o_full=1 and nack. Then assert i_clear in IDLE: all outputs return to reset values. Then assert w_rst mid-PILE: no ack is issued and move_count=0.
